// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// IF_PREFETCH_BUF_EN selects a 2-entry fetch buffer; otherwise 1 entry.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } if_state_e;

  localparam int unsigned INSTR_BYTES = 4;

`ifdef IF_PREFETCH_BUF_EN
  localparam int unsigned IF_BUF_DEPTH = 2;
`else
  localparam int unsigned IF_BUF_DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory request/response, redirect and decode handshake.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Parameterised-depth FIFO of {pc, instr}; head is read straight from storage registers.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH       = 1,
  parameter if_entry_t   RESET_ENTRY = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  if_entry_t push_data_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output logic      full_o,
  output logic      empty_o,
  output logic      almost_full_o,
  output if_entry_t head_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RESET_ENTRY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      // stale data stays in storage; it is never visible because empty_o masks it
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CW'(DEPTH));
  assign almost_full_o = (count_q == CW'(DEPTH - 1));
  assign head_o        = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory fetcher feeding a FIFO toward decode.
// Define IF_PREFETCH_BUF_EN for a 2-entry buffer so fetch can run ahead of a stalled decode.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);
  // state | meaning
  // IDLE  | after reset, or waiting for a free buffer entry
  // REQ   | imem_req high for one cycle at fetch_pc
  // WAIT  | request outstanding, waiting for imem_valid
  // DROP  | redirected while outstanding; next response is discarded

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        push, pop, full, empty, almost_full, space_after_push;
  if_entry_t   head;

  assign push = (state_q == WAIT) && bus.imem_valid && !bus.redirect_valid;
  assign pop  = !empty && bus.id_ready && !bus.redirect_valid;
  assign space_after_push = !(almost_full && !pop);

  fetch_buffer #(
    .DEPTH       (IF_BUF_DEPTH),
    .RESET_ENTRY (if_entry_t'({RESET_PC, 32'h0000_0000}))
  ) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_data_i   (if_entry_t'({fetch_pc_q, bus.imem_rdata})),
    .pop_i         (pop),
    .flush_i       (bus.redirect_valid),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almost_full),
    .head_o        (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      // a request issued this cycle or still unanswered must be drained first
      if (state_q == REQ || ((state_q == WAIT || state_q == DROP) && !bus.imem_valid))
        state_d = DROP;
      else
        state_d = REQ;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      unique case (state_q)
        IDLE:    if (!full || pop) state_d = REQ;
        REQ:     state_d = WAIT;
        WAIT:    if (bus.imem_valid) state_d = space_after_push ? REQ : IDLE;
        DROP:    if (bus.imem_valid) state_d = full ? IDLE : REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req  = (state_q == REQ);
    bus.imem_addr = fetch_pc_q >> 2;
    bus.if_valid  = !empty;
    bus.if_instr  = head.instr;
    bus.if_pc     = head.pc;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte PC loaded at reset.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1: fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32: word index sent to memory, equal to pc >> 2.
REQ-006 SHALL have port imem_valid  input  1: memory response strobe.
REQ-007 SHALL have port imem_rdata  input  32: instruction word, qualified by imem_valid.
REQ-008 SHALL have port redirect_valid  input  1: branch/jump taken; flush and restart.
REQ-009 SHALL have port redirect_pc  input  32: byte target PC; bits [1:0] ignored and treated as 0.
REQ-010 SHALL have port if_valid  output  1: instruction available to decode.
REQ-011 SHALL have port if_instr  output  32: instruction word.
REQ-012 SHALL have port if_pc  output  32: byte PC of if_instr.
REQ-013 SHALL have port id_ready  input  1: decode accepts; transfer occurs when if_valid && id_ready.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, DROP.
REQ-015 IDLE: exited to REQ on the first clock after reset release.
REQ-016 REQ: assert imem_req for exactly one cycle with imem_addr = fetch_pc >> 2, then go to WAIT; enter REQ only when the buffer has a free entry.
REQ-017 WAIT: hold imem_req low; on imem_valid, push {fetch_pc, imem_rdata}, advance fetch_pc by 4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0), then go to REQ if space remains, else IDLE-wait for space.
REQ-018 At most one request SHALL be outstanding; the response latency is unbounded, with a minimum of 1 cycle after imem_req.
REQ-019 redirect_valid SHALL flush all buffered entries in the same cycle, load fetch_pc = redirect_pc & ~3, and go to REQ; if a request is outstanding (WAIT), go to DROP instead.
REQ-020 DROP: discard the next imem_valid response without pushing it, then go to REQ with the redirected PC.
REQ-021 redirect_valid SHALL take priority over a same-cycle imem_valid, which is discarded, and over a same-cycle decode transfer; no flushed entry SHALL appear on if_valid after the redirect edge.
REQ-022 If buffer push and pop occur in the same cycle, both SHALL complete and occupancy SHALL be unchanged.
REQ-023 if_valid, if_instr and if_pc SHALL come directly from the buffer head register, with no combinational path from imem_rdata.
REQ-024 if_instr and if_pc SHALL remain stable while if_valid && !id_ready.
REQ-025 The buffer SHALL be a FIFO: instructions are delivered in ascending PC order between redirects.

Reset
REQ-026 Reset SHALL clear the following: state = IDLE, fetch_pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC >> 2, if_valid = 0, if_instr = 0, if_pc = RESET_PC, buffer empty.
REQ-027 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late imem_valid after release, seen while in IDLE, SHALL be ignored.

Configuration
REQ-028 Macro IF_PREFETCH_BUF_EN, when defined, SHALL set the buffer to 2 entries, so the next fetch may issue while decode stalls.
REQ-029 Without IF_PREFETCH_BUF_EN, the buffer SHALL have 1 entry and no request SHALL issue until that entry is popped; all other behaviour is identical.

Structure
REQ-030 The shared package mips_pkg SHALL hold the FSM state typedef, the constant INSTR_BYTES = 4, and the constant IF_BUF_DEPTH (selected by the macro).
REQ-031 The buffer SHALL be the sub-module fetch_buffer: a parameterised-depth FIFO with push, pop, flush, full and empty.

Verification
REQ-032 Reset with RESET_PC = 0 and 1-cycle memory returning memo[0] = 32'h22310000, then id_ready = 1 -> first if_valid with if_pc = 0 and if_instr = 32'h22310000; imem_addr sequence 0, 1, 2, 3.
REQ-033 id_ready held at 0 for 10 cycles -> with the macro, exactly 2 responses are buffered and imem_req stays low afterwards; without it, 1; if_instr is stable throughout.
REQ-034 redirect_valid with redirect_pc = 32'h0000_0010 while in WAIT, with a 3-cycle memory -> that late response is dropped, next imem_addr = 4, next if_pc = 32'h10.
REQ-035 redirect_valid in the same cycle as imem_valid -> the response is discarded and next if_pc = redirect target.
REQ-036 redirect_pc = 32'hFFFF_FFFC, then two fetches -> if_pc sequence FFFF_FFFC, 0000_0000.
REQ-037 Assert rst_n = 0 mid-WAIT, then release with imem_valid pulsed -> no if_valid from that stale response; fetch restarts at RESET_PC.
